// File: rtl/clk_div_pkg.sv
// Shared constants, types and helpers for the multi-channel clock divider.
package clk_div_pkg;

  localparam int unsigned DIV_W_DEFAULT = 16;
  localparam int unsigned DEFAULT_DIV   = 24999;

  typedef logic [DIV_W_DEFAULT-1:0] div_t;

  // Per-cycle counter action chosen by a channel
  typedef enum logic [1:0] {
    ACT_CLEAR  = 2'd0,
    ACT_TOGGLE = 2'd1,
    ACT_COUNT  = 2'd2
  } chan_act_e;

  // Clock cycles spent in each output level for a given divisor
  function automatic int unsigned half_period(input div_t div);
    return 32'(div) + 32'd1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/shadow divisor, square wave, rise tick.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int unsigned      DIV_W     = DIV_W_DEFAULT,
  parameter logic [DIV_W-1:0] RESET_DIV = DIV_W'(DEFAULT_DIV)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_data,
  output logic             clkout,
  output logic             tick,
  output logic             pending
);

  logic [DIV_W-1:0] count;
  logic [DIV_W-1:0] active;
  logic [DIV_W-1:0] shadow;
  logic             terminal;
  logic             commit;
  chan_act_e        act;

  assign terminal = (count == active);
  // The counter only ever compares against the committed divisor
  assign commit   = sync_clr || !en || terminal;

  always_comb begin
    act = ACT_COUNT;
    if (sync_clr || !en) act = ACT_CLEAR;
    else if (terminal)   act = ACT_TOGGLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count   <= '0;
      clkout  <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
      active  <= RESET_DIV;
      shadow  <= RESET_DIV;
    end else begin
      if (wr) shadow <= wr_data;

      // A write landing on a commit cycle bypasses the shadow register
      if (commit) begin
        active  <= wr ? wr_data : shadow;
        pending <= 1'b0;
      end else if (wr) begin
        pending <= 1'b1;
      end

      case (act)
        ACT_CLEAR: begin
          count  <= '0;
          clkout <= 1'b0;
          tick   <= 1'b0;
        end
        ACT_TOGGLE: begin
          count  <= '0;
          clkout <= ~clkout;
          tick   <= ~clkout;
        end
        default: begin
          count  <= count + 1'b1;
          tick   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider with glitch-free divisor updates.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned DIV_W       = DIV_W_DEFAULT,
  parameter int unsigned DEFAULT_DIV = clk_div_pkg::DEFAULT_DIV,
  localparam int unsigned WR_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  en,
  input  logic             sync_clr,
  input  logic             wr_en,
  input  logic [WR_W-1:0]  wr_ch,
  input  logic [DIV_W-1:0] wr_data,
  output logic [N_CH-1:0]  clkout,
  output logic [N_CH-1:0]  tick,
  output logic [N_CH-1:0]  pending
);

  logic [N_CH-1:0] wr_hit;

  // Indices with no matching channel decode to no strobe at all
  always_comb begin
    wr_hit = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (wr_en && (32'(wr_ch) == i)) wr_hit[i] = 1'b1;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    clk_div_chan #(
      .DIV_W     (DIV_W),
      .RESET_DIV (DIV_W'(DEFAULT_DIV))
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .en       (en[g]),
      .sync_clr (sync_clr),
      .wr       (wr_hit[g]),
      .wr_data  (wr_data),
      .clkout   (clkout[g]),
      .tick     (tick[g]),
      .pending  (pending[g])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Directed bench for clk_div_multi: timing, divisor commit rules, sync_clr, reset.
module tb_clk_div_multi;

  logic        clk;
  logic        reset;
  logic [3:0]  en;
  logic        sync_clr;
  logic        wr_en;
  logic [1:0]  wr_ch;
  logic [15:0] wr_data;
  logic [3:0]  clkout, tick, pending;

  // Three-channel instance so an out-of-range channel index is representable
  logic [2:0]  en3;
  logic        sync_clr3, wr_en3;
  logic [1:0]  wr_ch3;
  logic [7:0]  wr_data3;
  logic [2:0]  clkout3, tick3, pending3;

  int errors = 0;
  int checks = 0;
  int n;

  clk_div_multi #(.N_CH(4), .DIV_W(16), .DEFAULT_DIV(24999)) dut (
    .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_data(wr_data), .clkout(clkout), .tick(tick), .pending(pending)
  );

  clk_div_multi #(.N_CH(3), .DIV_W(8), .DEFAULT_DIV(2)) dut3 (
    .clk(clk), .reset(reset), .en(en3), .sync_clr(sync_clr3), .wr_en(wr_en3),
    .wr_ch(wr_ch3), .wr_data(wr_data3), .clkout(clkout3), .tick(tick3), .pending(pending3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [1:0] ch, input logic [15:0] data);
    wr_en = 1'b1; wr_ch = ch; wr_data = data;
    step(1);
    wr_en = 1'b0;
  endtask

  initial begin
    reset = 1'b0; en = '0; sync_clr = 1'b0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
    en3 = '0; sync_clr3 = 1'b0; wr_en3 = 1'b0; wr_ch3 = '0; wr_data3 = '0;
    step(2);
    chk("reset_clkout", 32'(clkout), 32'h0);
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_pending", 32'(pending), 32'h0);
    reset = 1'b1;

    // Default divisor 24999: first rise after 25000 enabled cycles
    en = 4'b0001;
    n = 0;
    while (clkout[0] !== 1'b1 && n < 30000) begin step(1); n++; end
    chk("ch0_first_rise_cycle", n, 25000);
    chk("ch0_tick_at_rise", 32'(tick), 32'h1);
    chk("others_idle", 32'(clkout[3:1]), 32'h0);
    step(1);
    chk("ch0_tick_one_cycle", 32'(tick[0]), 32'h0);
    chk("ch0_high_hold", 32'(clkout[0]), 32'h1);
    en = '0;
    step(1);
    chk("ch0_en_low_clear", 32'({clkout[0], tick[0]}), 32'h0);

    // div=0 on ch1 while disabled commits at once; output is clk/2
    write(2'd1, 16'd0);
    chk("ch1_write_en_low_no_pending", 32'(pending[1]), 32'h0);
    en = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk("ch1_div0_clkout", 32'(clkout[1]), 32'((i % 2) == 0));
      chk("ch1_div0_tick", 32'(tick[1]), 32'((i % 2) == 0));
    end
    en = '0;

    // ch2 div=9, write 3 at count=4: current half stays 10, then 4
    write(2'd2, 16'd9);
    en = 4'b0100;
    step(4);
    write(2'd2, 16'd3);
    chk("ch2_pending_set", 32'(pending[2]), 32'h1);
    step(4);
    chk("ch2_no_early_rise", 32'({clkout[2], pending[2]}), 32'h1);
    step(1);
    chk("ch2_rise_at_10", 32'({clkout[2], tick[2], pending[2]}), 32'h6);
    step(3);
    chk("ch2_high_hold", 32'(clkout[2]), 32'h1);
    step(1);
    chk("ch2_fall_after_4", 32'(clkout[2]), 32'h0);
    step(4);
    chk("ch2_rise_after_4", 32'({clkout[2], tick[2]}), 32'h3);
    en = '0;

    // ch3 div=5, write 2 exactly on the terminal cycle
    write(2'd3, 16'd5);
    en = 4'b1000;
    step(5);
    write(2'd3, 16'd2);
    chk("ch3_rise_on_write", 32'({clkout[3], tick[3], pending[3]}), 32'h6);
    step(2);
    chk("ch3_high_no_pending", 32'({clkout[3], pending[3]}), 32'h2);
    step(1);
    chk("ch3_fall_after_3", 32'(clkout[3]), 32'h0);
    step(3);
    chk("ch3_rise_after_3", 32'({clkout[3], tick[3]}), 32'h3);
    en = '0;

    // Out-of-range channel index is ignored; default div 2 rises at cycle 3
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_data3 = 8'd0;
    step(1);
    wr_en3 = 1'b0;
    chk("oor_no_pending", 32'(pending3), 32'h0);
    en3 = 3'b111;
    step(2);
    chk("oor_no_early_rise", 32'(clkout3), 32'h0);
    step(1);
    chk("oor_rise_at_3", 32'({clkout3, tick3}), 32'h3F);

    // sync_clr re-aligns ch0 (div 4) and ch1 (div 9)
    write(2'd0, 16'd4);
    write(2'd1, 16'd9);
    en = 4'b0011;
    step(7);
    sync_clr = 1'b1;
    step(1);
    sync_clr = 1'b0;
    chk("sync_clr_clear", 32'({clkout[1:0], tick[1:0]}), 32'h0);
    step(4);
    chk("sync_pre_rise", 32'(clkout[1:0]), 32'h0);
    step(1);
    chk("sync_ch0_rise_5", 32'({clkout[1:0], tick[1:0]}), 32'h5);
    step(4);
    chk("sync_ch0_hold", 32'(clkout[1:0]), 32'h1);
    step(1);
    chk("sync_ch1_rise_10", 32'({clkout[1:0], tick[1:0]}), 32'hA);

    // Pending commits on sync_clr; coincident write commits wr_data
    write(2'd0, 16'd7);
    chk("ch0_pending_running", 32'(pending[1:0]), 32'h1);
    sync_clr = 1'b1; wr_en = 1'b1; wr_ch = 2'd1; wr_data = 16'd1;
    step(1);
    sync_clr = 1'b0; wr_en = 1'b0;
    chk("sync_commit_pending", 32'({pending[1:0], clkout[1:0]}), 32'h0);
    step(2);
    chk("sync_wr_ch1_div1", 32'(clkout[1:0]), 32'h2);
    step(6);
    chk("sync_ch0_div7", 32'({clkout[1:0], tick[1:0]}), 32'h5);

    // Asynchronous reset mid-run clears everything and restores DEFAULT_DIV
    write(2'd1, 16'd5);
    chk("pre_reset_state", 32'({pending, clkout}), 32'h21);
    reset = 1'b0;
    #1;
    chk("async_reset_outputs", 32'({clkout, tick, pending}), 32'h0);
    chk("async_reset_dut3", 32'({clkout3, tick3, pending3}), 32'h0);
    step(2);
    reset = 1'b1;
    en = 4'b0001;
    n = 0;
    while (clkout[0] !== 1'b1 && n < 30000) begin step(1); n++; end
    chk("default_div_restored", n, 25000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
